// File: rtl/soc_arb_pkg.sv
// Shared definitions for the SoC memory arbiter: state encoding, master
// port indices, wait-counter width and small helper functions.
package soc_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  localparam int M_CPU      = 0;
  localparam int M_DMA      = 1;
  localparam int WAIT_CNT_W = 4;

  // One-hot select for a master index (bit 0 = CPU, bit 1 = DMA).
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

  // Saturating 16-bit increment used by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/arb_rr_pick2.sv
// Combinational two-way round-robin picker. The pointer register lives in
// the parent; this block only decides who wins the current request set.
module arb_rr_pick2
  import soc_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       valid,
  output logic       winner
);

  // A lone requester wins outright; a tie goes to the port the pointer favours.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ptr;
    end else if (req[M_DMA]) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/soc_mem_arbiter.sv
// Two-master arbiter sharing the single-port word memory between the CPU
// (port 0) and the DMA/loader (port 1). One transfer at a time:
// IDLE -> ACCESS (WAIT_STATES+1 cycles) -> RESP -> IDLE.
// Optional build macro MEM_ARB_STATS_EN adds saturating grant/conflict
// counters with a synchronous clear input.
module soc_mem_arbiter
  import soc_arb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 0
)
(
  input  logic          clk,
  input  logic          rst_b,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef MEM_ARB_STATS_EN
  input  logic          stat_clr,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_conflict,
`endif
  output logic          busy
);

  // WAIT_STATES is expected in 0..15 so it fits the 4-bit down-counter.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

  arb_state_e            state_q, state_d;
  logic                  rr_ptr_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  owner_q;
  logic                  own_we_q;
  logic [AW-1:0]         own_addr_q;
  logic [DW-1:0]         own_wdata_q;
  logic [1:0]            gnt_q;
  logic [1:0]            ack_q;
  logic [DW-1:0]         rdata0_q;
  logic [DW-1:0]         rdata1_q;

  logic                  pick_valid;
  logic                  pick_winner;
  logic                  do_grant;
  logic                  access_done;

  arb_rr_pick2 u_pick (
    .req    ({m1_req, m0_req}),
    .ptr    (rr_ptr_q),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic plus the grant/complete events the datapath acts on.
  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    access_done = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d  = ST_ACCESS;
          do_grant = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (wait_cnt_q == '0) begin
          state_d     = ST_RESP;
          access_done = 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's request, move the round-robin pointer, pulse gnt and
  // run the wait-state down-counter through ACCESS.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rr_ptr_q    <= 1'b0;
      wait_cnt_q  <= '0;
      owner_q     <= 1'b0;
      own_we_q    <= 1'b0;
      own_addr_q  <= '0;
      own_wdata_q <= '0;
      gnt_q       <= 2'b00;
    end else begin
      gnt_q <= 2'b00;
      if (do_grant) begin
        owner_q     <= pick_winner;
        rr_ptr_q    <= ~pick_winner;
        gnt_q       <= port_onehot(pick_winner);
        own_we_q    <= pick_winner ? m1_we    : m0_we;
        own_addr_q  <= pick_winner ? m1_addr  : m0_addr;
        own_wdata_q <= pick_winner ? m1_wdata : m0_wdata;
        wait_cnt_q  <= WAIT_LOAD;
      end else if ((state_q == ST_ACCESS) && (wait_cnt_q != '0)) begin
        wait_cnt_q <= wait_cnt_q - WAIT_CNT_W'(1);
      end
    end
  end

  // Capture read data for the owner at the end of ACCESS and pulse its ack
  // during RESP; the other port's ack and rdata are left alone.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ack_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack_q <= 2'b00;
      if (access_done) begin
        ack_q <= port_onehot(owner_q);
        if (!own_we_q) begin
          if (owner_q) begin
            rdata1_q <= mem_rdata;
          end else begin
            rdata0_q <= mem_rdata;
          end
        end
      end
    end
  end

  // Strobes are decoded from state so they fall the instant reset asserts.
  always_comb begin
    mem_read    = (state_q == ST_ACCESS) && !own_we_q;
    mem_write   = (state_q == ST_ACCESS) &&  own_we_q;
    mem_address = own_addr_q;
    mem_wdata   = own_wdata_q;
    busy        = (state_q != ST_IDLE);
    m0_gnt      = gnt_q[M_CPU];
    m1_gnt      = gnt_q[M_DMA];
    m0_ack      = ack_q[M_CPU];
    m1_ack      = ack_q[M_DMA];
    m0_rdata    = rdata0_q;
    m1_rdata    = rdata1_q;
  end

`ifdef MEM_ARB_STATS_EN
  // Saturating per-port grant counts and tie counts; clear wins over increment.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else if (do_grant) begin
      if (pick_winner) begin
        stat_gnt1 <= sat_inc16(stat_gnt1);
      end else begin
        stat_gnt0 <= sat_inc16(stat_gnt0);
      end
      if (m0_req && m1_req) begin
        stat_conflict <= sat_inc16(stat_conflict);
      end
    end
  end
`endif

endmodule

// File: tb/tb_soc_mem_arbiter.sv
// Self-checking bench for soc_mem_arbiter. A transaction-level model decides
// which master owns the memory and when, pushing expected gnt/ack events and
// per-cycle strobe expectations; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_soc_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int WS = 2;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_read, mem_write, busy;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic          stat_clr;
  logic [15:0]   stat_gnt0, stat_gnt1, stat_conflict;
`endif

  always #5 clk = ~clk;

  soc_mem_arbiter #(.AW(AW), .DW(DW), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_ack      (m0_ack),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_ack      (m1_ack),
    .m1_rdata    (m1_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
`ifdef MEM_ARB_STATS_EN
    .stat_clr      (stat_clr),
    .stat_gnt0     (stat_gnt0),
    .stat_gnt1     (stat_gnt1),
    .stat_conflict (stat_conflict),
`endif
    .busy        (busy)
  );

  // Memory contents at power-up: a fixed pattern, with 0x0010 holding 0x1234.
  function automatic logic [15:0] init_word(input int a);
    if (a == 16'h0010) return 16'h1234;
    return 16'(a) ^ 16'hA5C3;
  endfunction

  // Single-port memory seen by the arbiter: combinational read, clocked write.
  logic [DW-1:0] mem [0:65535];
  assign mem_rdata = mem[mem_address];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_wdata;
  end

  typedef struct {
    int          cyc;
    int          port;
    bit          is_ack;
    bit          is_read;
    logic [15:0] data;
  } evt_t;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  evt_t        exp_q[$];
  acc_t        exp_acc[int];
  bit          exp_busy[int];
  logic [15:0] exp_rd [2];
  logic [15:0] ref_mem [int];

  bit          pend [2];
  bit          granted [2];
  bit          p_we [2];
  logic [15:0] p_addr [2];
  logic [15:0] p_data [2];

  int cyc;
  int free_at;
  bit rr_ptr;
  bit mon_en;
  int vectors;
  int miscompares;
  int gnt_cnt [2];
  int conf_cnt;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cyc=%0d: got 0x%0h, expected 0x%0h",
               name, cyc, actual, expected);
    end
  endtask

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_word(int'(a));
  endfunction

  // Drive the DUT request inputs from the master driver state.
  task automatic drive_inputs();
    m0_req = pend[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_data[0];
    m1_req = pend[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_data[1];
  endtask

  task automatic issue(input int p, input bit we, input logic [15:0] a,
                       input logic [15:0] d);
    pend[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_data[p] = d;
    drive_inputs();
  endtask

  task automatic random_req(input int p);
    logic [15:0] a;
    case ($urandom_range(0, 9))
      0:       a = 16'hFFFF;
      1:       a = 16'h0000;
      2:       a = 16'h0010;
      default: a = 16'($urandom_range(0, 31));
    endcase
    issue(p, 1'($urandom_range(0, 1)), a, 16'($urandom));
  endtask

  // Transaction-level model: when the memory is free and someone asks, the
  // sole requester (or the favoured one on a tie) owns it for WS+1 access
  // cycles, gets ack one cycle later, and the memory is free WS+3 after.
  task automatic model_step();
    int          w;
    bit          both;
    logic [15:0] rd;
    if (cyc >= free_at && (pend[0] || pend[1])) begin
      both = pend[0] && pend[1];
      if (both) w = int'(rr_ptr);
      else      w = pend[1] ? 1 : 0;
      rr_ptr = (w == 0);
      gnt_cnt[w]++;
      if (both) conf_cnt++;
      exp_q.push_back('{cyc, w, 1'b0, 1'b0, 16'h0});
      for (int i = 0; i <= WS; i++) exp_acc[cyc + i] = '{p_we[w], p_addr[w], p_data[w]};
      for (int i = 0; i <= WS + 1; i++) exp_busy[cyc + i] = 1'b1;
      rd = ref_read(p_addr[w]);
      if (p_we[w]) ref_mem[int'(p_addr[w])] = p_data[w];
      exp_q.push_back('{cyc + WS + 1, w, 1'b1, !p_we[w], rd});
      free_at = cyc + WS + 3;
      granted[w] = 1'b1;
    end
  endtask

  // Masters drop a granted request and, at the given percentage rate,
  // raise a fresh one whenever they have nothing outstanding.
  task automatic applyStimulus(input int rate);
    for (int p = 0; p < 2; p++) begin
      if (granted[p]) begin
        pend[p] = 1'b0;
        granted[p] = 1'b0;
      end
      if (!pend[p] && ($urandom_range(0, 99) < rate)) random_req(p);
    end
    drive_inputs();
  endtask

  task automatic run_cycles(input int n, input int rate);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      applyStimulus(rate);
    end
  endtask

  task automatic drain();
    run_cycles(3 * (WS + 3), 0);
    checkOutput("events_outstanding", exp_q.size(), 0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    exp_acc.delete();
    exp_busy.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    rr_ptr    = 1'b0;
    free_at   = 1;
    cyc       = 0;
    gnt_cnt[0] = 0;
    gnt_cnt[1] = 0;
    conf_cnt  = 0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; granted[p] = 1'b0; p_we[p] = 1'b0;
      p_addr[p] = '0; p_data[p] = '0;
    end
    drive_inputs();
  endtask

  task automatic check_quiet(input string tag);
    checkOutput({tag, "_mem_read"},  mem_read,  1'b0);
    checkOutput({tag, "_mem_write"}, mem_write, 1'b0);
    checkOutput({tag, "_busy"},      busy,      1'b0);
    checkOutput({tag, "_m0_ack"},    m0_ack,    1'b0);
    checkOutput({tag, "_m1_ack"},    m1_ack,    1'b0);
    checkOutput({tag, "_m0_gnt"},    m0_gnt,    1'b0);
    checkOutput({tag, "_m1_gnt"},    m1_gnt,    1'b0);
    checkOutput({tag, "_mem_addr"},  mem_address, 16'h0000);
    checkOutput({tag, "_m0_rdata"},  m0_rdata,  16'h0000);
    checkOutput({tag, "_m1_rdata"},  m1_rdata,  16'h0000);
  endtask

  // Monitor: every cycle, pop the event due now and compare all handshake
  // outputs, held read data, busy and the memory strobes.
  initial begin : monitor
    forever begin
      evt_t       e;
      logic [1:0] eg;
      logic [1:0] ea;
      acc_t       a;
      @(negedge clk);
      if (mon_en) begin
        eg = 2'b00;
        ea = 2'b00;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          e = exp_q.pop_front();
          if (e.is_ack) begin
            ea[e.port] = 1'b1;
            if (e.is_read) exp_rd[e.port] = e.data;
          end else begin
            eg[e.port] = 1'b1;
          end
        end
        checkOutput("m0_gnt", m0_gnt, eg[0]);
        checkOutput("m1_gnt", m1_gnt, eg[1]);
        checkOutput("m0_ack", m0_ack, ea[0]);
        checkOutput("m1_ack", m1_ack, ea[1]);
        checkOutput("m0_rdata", m0_rdata, exp_rd[0]);
        checkOutput("m1_rdata", m1_rdata, exp_rd[1]);
        checkOutput("busy", busy, exp_busy.exists(cyc));
        if (exp_acc.exists(cyc)) begin
          a = exp_acc[cyc];
          checkOutput("mem_read", mem_read, !a.we);
          checkOutput("mem_write", mem_write, a.we);
          checkOutput("mem_address", mem_address, a.addr);
          if (a.we) checkOutput("mem_wdata", mem_wdata, a.wdata);
        end else begin
          checkOutput("mem_read", mem_read, 1'b0);
          checkOutput("mem_write", mem_write, 1'b0);
        end
      end
    end
  end

  initial begin : stimulus
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    rst_b       = 1'b0;
`ifdef MEM_ARB_STATS_EN
    stat_clr    = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = init_word(i);
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_b  = 1'b1;
    cyc    = 0;
    mon_en = 1'b1;

    $display("[TB] directed: CPU read of 0x0010");
    issue(0, 1'b0, 16'h0010, 16'h0000);
    drain();
    checkOutput("m0_rdata_0010", m0_rdata, 16'h1234);

    $display("[TB] directed: DMA write 0xBEEF to 0x01FF");
    issue(1, 1'b1, 16'h01FF, 16'hBEEF);
    drain();
    checkOutput("mem_01FF", mem[16'h01FF], 16'hBEEF);
    issue(0, 1'b0, 16'h01FF, 16'h0000);
    drain();
    checkOutput("m0_rdata_01FF", m0_rdata, 16'hBEEF);

    $display("[TB] directed: both masters requesting back to back");
    run_cycles(4 * (WS + 3), 100);
    drain();
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_conflict_contention", stat_conflict, conf_cnt);
`endif

    $display("[TB] random traffic");
    run_cycles(600, 30);
    run_cycles(600, 90);
    drain();
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_gnt0", stat_gnt0, gnt_cnt[0]);
    checkOutput("stat_gnt1", stat_gnt1, gnt_cnt[1]);
    checkOutput("stat_conflict", stat_conflict, conf_cnt);
    mon_en = 1'b0;
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    checkOutput("stat_gnt0_clr", stat_gnt0, 16'h0000);
    checkOutput("stat_gnt1_clr", stat_gnt1, 16'h0000);
    checkOutput("stat_conflict_clr", stat_conflict, 16'h0000);
    gnt_cnt[0] = 0;
    gnt_cnt[1] = 0;
    conf_cnt   = 0;
    mon_en = 1'b1;
`endif

    $display("[TB] directed: reset in the middle of a DMA read");
    issue(1, 1'b0, 16'h0005, 16'h0000);
    run_cycles(1, 0);
    checkOutput("pre_reset_mem_read", mem_read, 1'b1);
    mon_en = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    reset_model();
    check_quiet("midreset");
    repeat (WS + 3) begin
      @(negedge clk);
      checkOutput("midreset_m1_ack", m1_ack, 1'b0);
    end
    @(posedge clk);
    #1;
    rst_b  = 1'b1;
    mon_en = 1'b1;
    issue(1, 1'b0, 16'h0007, 16'h0000);
    issue(0, 1'b0, 16'h0008, 16'h0000);
    run_cycles(1, 0);
    checkOutput("post_reset_winner_m0", gnt_cnt[0], 1);
    drain();
    run_cycles(200, 60);
    drain();
`ifdef MEM_ARB_STATS_EN
    checkOutput("stat_gnt0_final", stat_gnt0, gnt_cnt[0]);
    checkOutput("stat_gnt1_final", stat_gnt1, gnt_cnt[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
